// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-cycle shared memory interface.
// Data accesses win contention until fetch has lost STARVE_MAX cycles in a row.
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 2
`endif

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int CNT_W      = 2,
  parameter int STARVE_MAX = 4,
  localparam int STARVE_W  = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rd_valid,
  output logic [WORD_W-1:0]   if_rd_data,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_wr_en,
  input  logic [WORD_W-1:0]   d_wr_data,
  input  logic [CNT_W-1:0]    d_count,
  output logic                d_gnt,
  output logic                d_done,
  output logic [WORD_W-1:0]   d_rd_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [WORD_W-1:0]   mem_req_wr_data,
  output logic                mem_req_wr_en,
  output logic [CNT_W-1:0]    mem_req_count,
  input  logic [WORD_W-1:0]   mem_res_rd_data,
  output logic                fe_stall,
  output logic                me_stall,
  output logic [1:0]          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  // Handshake: a requester raises *_req with a stable payload and holds both until
  // the matching *_gnt is high in the same cycle; the response (rd_valid / done)
  // comes exactly one cycle after the grant, and a new grant may overlap it.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic                fetch_wins;

  always_comb begin
    fetch_wins = if_req & (~d_req | (starve_cnt == STARVE_W'(STARVE_MAX)));
    // Grants are masked during reset so nothing is issued while aresetn is low.
    if_gnt     = aresetn & fetch_wins;
    d_gnt      = aresetn & d_req & ~fetch_wins;
    fe_stall   = if_req & ~if_gnt;
    me_stall   = d_req & ~d_gnt;
  end

  always_comb begin
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wr_data = '0;
    mem_req_wr_en   = 1'b0;
    mem_req_count   = '0;
    if (if_gnt) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = if_addr;
      mem_req_count = CNT_W'(`MEM_COUNT_WORD);
    end else if (d_gnt) begin
      mem_req_valid   = 1'b1;
      mem_req_addr    = d_addr;
      mem_req_wr_data = d_wr_data;
      mem_req_wr_en   = d_wr_en;
      mem_req_count   = d_count;
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    starve_nxt = '0;
    if (if_gnt)
      state_nxt = RESP_IF;
    else if (d_gnt)
      state_nxt = RESP_D;
    if (if_req & ~if_gnt)
      starve_nxt = (starve_cnt == STARVE_W'(STARVE_MAX)) ? starve_cnt
                                                         : starve_cnt + STARVE_W'(1);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    if_rd_valid = 1'b0;
    if_rd_data  = '0;
    d_done      = 1'b0;
    d_rd_data   = '0;
    case (state)
      RESP_IF: begin
        if_rd_valid = 1'b1;
        if_rd_data  = mem_res_rd_data;
      end
      RESP_D: begin
        d_done    = 1'b1;
        d_rd_data = mem_res_rd_data;
      end
      default: ;
    endcase
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + random bench for mem_arbiter: reference arbitration model, memory model,
// and a response scoreboard of {port, data} entries checked one cycle after each grant.
module tb_mem_arbiter;
  localparam int AW = 32, WW = 32, CW = 2, SMAX = 4;
  localparam logic [1:0] WORD_CODE = 2'd2;
  localparam int EW = 34;

  logic          clk, aresetn;
  logic          if_req, if_gnt, if_rd_valid;
  logic [AW-1:0] if_addr;
  logic [WW-1:0] if_rd_data;
  logic          d_req, d_wr_en, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [WW-1:0] d_wr_data, d_rd_data;
  logic [CW-1:0] d_count;
  logic          mem_req_valid, mem_req_wr_en;
  logic [AW-1:0] mem_req_addr;
  logic [WW-1:0] mem_req_wr_data, mem_res_rd_data;
  logic [CW-1:0] mem_req_count;
  logic          fe_stall, me_stall;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_starve_cnt;

  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_starve = 0;
  logic g_if, g_d;

  mem_arbiter #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .aresetn(aresetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rd_valid(if_rd_valid), .if_rd_data(if_rd_data),
    .d_req(d_req), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_wr_data(d_wr_data),
    .d_count(d_count), .d_gnt(d_gnt), .d_done(d_done), .d_rd_data(d_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_wr_data(mem_req_wr_data), .mem_req_wr_en(mem_req_wr_en),
    .mem_req_count(mem_req_count), .mem_res_rd_data(mem_res_rd_data),
    .fe_stall(fe_stall), .me_stall(me_stall),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // memory model: data one cycle after an accepted request, noise otherwise
  always @(posedge clk)
    mem_res_rd_data <= mem_req_valid ? mem_fn(mem_req_addr) : $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    logic [EW-1:0] e;
    logic [1:0]    p;
    logic [31:0]   d;
    chk("q_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    p = e[33:32];
    d = e[31:0];
    chk("if_rd_valid", 64'(if_rd_valid), 64'(p == 2'd1));
    chk("if_rd_data", 64'(if_rd_data), 64'((p == 2'd1) ? d : 32'd0));
    chk("d_done", 64'(d_done), 64'(p >= 2'd2));
    if (p != 2'd3) chk("d_rd_data", 64'(d_rd_data), 64'((p == 2'd2) ? d : 32'd0));
    chk("state", 64'(dbg_state), 64'((p == 2'd0) ? 2'd0 : (p == 2'd1) ? 2'd1 : 2'd2));
  endtask

  // driver: one cycle, called at a negedge, returns at the next negedge
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [31:0] da, input logic dw, input logic [31:0] dwd,
                      input logic [1:0] dc);
    logic       eif, ed;
    logic [1:0] p;
    check_resp();
    if_req = ir; if_addr = ia;
    d_req = dr; d_addr = da; d_wr_en = dw; d_wr_data = dwd; d_count = dc;
    #1;
    eif = ir && (!dr || m_starve == SMAX);
    ed  = dr && !eif;
    chk("if_gnt", 64'(if_gnt), 64'(eif));
    chk("d_gnt", 64'(d_gnt), 64'(ed));
    chk("gnt_excl", 64'(if_gnt & d_gnt), 64'd0);
    chk("fe_stall", 64'(fe_stall), 64'(ir && !eif));
    chk("me_stall", 64'(me_stall), 64'(dr && !ed));
    chk("mem_valid", 64'(mem_req_valid), 64'(eif || ed));
    chk("mem_addr", 64'(mem_req_addr), 64'(eif ? ia : ed ? da : 32'd0));
    chk("mem_wr_en", 64'(mem_req_wr_en), 64'(ed && dw));
    chk("mem_wr_data", 64'(mem_req_wr_data), 64'(ed ? dwd : 32'd0));
    chk("mem_count", 64'(mem_req_count), 64'(eif ? WORD_CODE : ed ? dc : 2'd0));
    p = eif ? 2'd1 : ed ? (dw ? 2'd3 : 2'd2) : 2'd0;
    exp_q.push_back({p, mem_fn(eif ? ia : da)});
    @(posedge clk);
    m_starve = (ir && !eif) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    #1 chk("starve_cnt", 64'(dbg_starve_cnt), 64'(m_starve));
    g_if = eif;
    g_d  = ed;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
  endtask

  initial begin
    logic        r_ir, r_dr, r_dw;
    logic [31:0] r_ia, r_da, r_dwd;
    logic [1:0]  r_dc;

    // reset held with both requesters active: nothing may be granted
    aresetn = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80;
    d_wr_en = 1'b0; d_wr_data = 32'h0; d_count = 2'd2;
    @(negedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_if_rd_valid", 64'(if_rd_valid), 64'd0);
    chk("rst_d_done", 64'(d_done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_starve", 64'(dbg_starve_cnt), 64'd0);

    // release and grant a fetch in the very first cycle
    aresetn = 1'b1;
    m_starve = 0;
    exp_q.push_back('0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    idle();

    // store then load, data only
    step(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 2'd2);
    step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 2'd1);
    idle();

    // contention: 4 data wins, then fetch, repeating
    for (int i = 0; i < 11; i++)
      step(1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h0, 2'd2);
    idle();

    // starve fetch twice, then drop d_req: fetch wins at once and the count clears
    step(1'b1, 32'h600, 1'b1, 32'h680, 1'b1, 32'h1234_5678, 2'd0);
    step(1'b1, 32'h600, 1'b1, 32'h684, 1'b0, 32'h0, 2'd2);
    step(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    idle();

    // random traffic, payload held until granted
    r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0;
    r_ia = 32'h0; r_da = 32'h0; r_dwd = 32'h0; r_dc = 2'd0;
    g_if = 1'b1; g_d = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (g_if || !r_ir) begin
        r_ir = 1'($urandom_range(0, 1));
        r_ia = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      end
      if (g_d || !r_dr) begin
        r_dr  = 1'($urandom_range(0, 1));
        r_da  = {16'h1, 14'($urandom_range(0, 16383)), 2'b00};
        r_dw  = 1'($urandom_range(0, 1));
        r_dwd = $urandom;
        r_dc  = 2'($urandom_range(0, 2));
      end
      step(r_ir, r_ia, r_dr, r_da, r_dw, r_dwd, r_dc);
    end

    // reset asserted while a fetch response is pending
    check_resp();
    if_req = 1'b1; if_addr = 32'h700; d_req = 1'b0; #1;
    chk("mid_if_gnt", 64'(if_gnt), 64'd1);
    aresetn = 1'b0; #1;
    chk("mid_rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_if_rd_valid", 64'(if_rd_valid), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_starve", 64'(dbg_starve_cnt), 64'd0);
    @(negedge clk);
    if_req = 1'b0;
    aresetn = 1'b1;
    m_starve = 0;
    exp_q.delete();
    exp_q.push_back('0);
    step(1'b1, 32'h704, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    idle();
    check_resp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter WORD_W, default 32, data width.
REQ-003 Parameter CNT_W, default 2, access-size code width; code for a full word is `MEM_COUNT_WORD`.
REQ-004 Parameter STARVE_MAX, default 4, consecutive fetch losses before fetch is forced to win.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 aresetn  input  1  asynchronous, active-low reset.
REQ-007 if_req  input  1  fetch stage requests an instruction read.
REQ-008 if_addr  input  ADDR_W  fetch address (PC).
REQ-009 if_gnt  output  1  fetch request accepted this cycle.
REQ-010 if_rd_valid  output  1  instruction data valid this cycle.
REQ-011 if_rd_data  output  WORD_W  instruction word.
REQ-012 d_req  input  1  memory stage requests a load or store.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wr_en  input  1  1 = store, 0 = load.
REQ-015 d_wr_data  input  WORD_W  store data.
REQ-016 d_count  input  CNT_W  access size code.
REQ-017 d_gnt  output  1  data request accepted this cycle.
REQ-018 d_done  output  1  data access completed this cycle (load data valid, or store acknowledged).
REQ-019 d_rd_data  output  WORD_W  load data.
REQ-020 mem_req_valid, mem_req_addr, mem_req_wr_data, mem_req_wr_en, mem_req_count  outputs  1/ADDR_W/WORD_W/1/CNT_W  request to the shared memory_interface.
REQ-021 mem_res_rd_data  input  WORD_W  memory response data, valid exactly one cycle after an accepted request.
REQ-022 fe_stall, me_stall  outputs  1  stall requests to the fetch and memory stages.

Function
REQ-023 Arbitration is combinational within a cycle; at most one of if_gnt, d_gnt is 1 in any cycle.
REQ-024 With only one requester active, that requester is granted.
REQ-025 With both active, d_req wins unless starve_cnt == STARVE_MAX, in which case if_req wins.
REQ-026 starve_cnt (width clog2(STARVE_MAX+1)) increments when if_req=1 and if_gnt=0, saturating at STARVE_MAX; it clears to 0 on any cycle with if_gnt=1 or if_req=0.
REQ-027 The mem_req_* outputs mirror the granted port; for a fetch grant: wr_en=0, wr_data=0, count=`MEM_COUNT_WORD`; with no grant, mem_req_valid=0 and the other mem_req_* outputs are 0.
REQ-028 The FSM has states IDLE, RESP_IF, RESP_D; the next state is RESP_IF after if_gnt, RESP_D after d_gnt, and IDLE otherwise, independent of the current state.
REQ-029 In RESP_IF: if_rd_valid=1 and if_rd_data=mem_res_rd_data; in RESP_D: d_done=1 and d_rd_data=mem_res_rd_data (content unspecified for stores).
REQ-030 In all other cases, if_rd_valid=0, d_done=0, and both data outputs are 0.
REQ-031 fe_stall = if_req & ~if_gnt; me_stall = d_req & ~d_gnt.
REQ-032 A new grant is allowed in the same cycle a response is returned (back-to-back throughput of one access per cycle).
REQ-033 A requester holds its req and payload stable until granted; the arbiter does not latch the payload.

Reset
REQ-034 While aresetn=0: the FSM is IDLE, starve_cnt=0, and if_gnt, d_gnt, mem_req_valid, if_rd_valid, and d_done are 0; all of these apply asynchronously.
REQ-035 An asynchronous reset asserted while a response is pending discards that response; no valid/done pulse follows deassertion.
REQ-036 The first grant is possible in the first posedge cycle after aresetn rises.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x100 for 3 cycles -> if_gnt=1 each cycle; mem_req_addr=0x100; if_rd_valid=1 on cycles 2-4 with data from memory; fe_stall=0.
REQ-038 Store only: d_req=1, d_wr_en=1, d_addr=0x200, d_wr_data=0xDEADBEEF -> d_gnt=1; mem_req_wr_en=1 with matching payload; d_done=1 the next cycle.
REQ-039 Contention: both requests held continuously with STARVE_MAX=4 -> data granted 4 cycles (fe_stall=1), fetch granted on the 5th, pattern repeats; responses route to the correct port.
REQ-040 Alternation: d_req drops the cycle after fetch was starved 2 cycles -> fetch granted immediately; starve_cnt returns to 0.
REQ-041 Reset mid-operation: grant a fetch, drop aresetn before the next edge -> if_rd_valid stays 0; after release, state is IDLE and starve_cnt=0.
REQ-042 Invariant check, all tests: if_gnt & d_gnt is never 1; every grant produces exactly one valid/done pulse one cycle later, absent reset.
